muldiv_ctrl: RTL and testbench

Iterative multiply/divide controller for the execute stage of the pipelined MIPS core. It sequences a radix-2 shift-add/restoring-subtract datapath to execute MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers. It stalls the pipeline when a dependent instruction arrives while it is busy; these are MFHI/MFLO or another mul/div op. It runs alongside the single-cycle ALU and shares the ID/EX operand buses with it.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_step.sv | 21 ++
 rtl/muldiv_ctrl.sv | 93 +++++++++
 tb/tb_muldiv_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state enum and sizes for the mul/div unit
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} md_state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/response bundle between the pipeline and the mul/div unit
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mf_read;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, mf_read, flush, input busy, stall, done, hi, lo);
  modport slave  (input start, op, a, b, mf_read, flush, output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, add-shift for multiply or restoring subtract-shift for divide
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  // multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    ge       = rem_sh >= {1'b0, opnd};
    diff     = rem_sh[WIDTH-1:0] - opnd;
    acc_next = is_div ? {ge ? diff : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                      : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MULDIV_SIGNED_EN enables signed ops and the FIX state
module muldiv_ctrl
  import muldiv_pkg::*;
#(parameter int WIDTH = MD_WIDTH) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
`ifdef MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] CALC = S_CALC;
  localparam logic [1:0] FIX  = S_FIX;
  logic [1:0]          state;
  logic [MD_CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0]  acc, acc_next, r, prod;
  logic [WIDTH-1:0]    opnd, a_raw, abs_a, abs_b, q, rm, new_hi, new_lo;
  logic                is_div, neg_q, neg_r, dz, done;
  logic [WIDTH-1:0]    hi, lo;
  logic                accept, is_md, is_mth, is_mtl, op_div, sgn_op, fin, wr;
  muldiv_step #(.WIDTH(WIDTH)) u_step (.is_div(is_div), .acc(acc), .opnd(opnd), .acc_next(acc_next));
  // request decode, operand magnitudes and result sign correction
  always_comb begin
    accept = (state == IDLE) & bus.start & ~bus.flush;
    is_md  = accept & (bus.op == MD_MULT | bus.op == MD_MULTU | bus.op == MD_DIV | bus.op == MD_DIVU);
    is_mth = accept & (bus.op == MD_MTHI);
    is_mtl = accept & (bus.op == MD_MTLO);
    op_div = bus.op == MD_DIV | bus.op == MD_DIVU;
    sgn_op = SGN & (bus.op == MD_MULT | bus.op == MD_DIV);
    abs_a  = (sgn_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b  = (sgn_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    fin    = SGN ? state == FIX : (state == CALC & cnt == 0);
    wr     = fin & ~bus.flush;
    r      = SGN ? acc : acc_next;
    prod   = neg_q ? -r : r;
    q      = neg_q ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    rm     = neg_r ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
    new_hi = is_div ? (dz ? a_raw : rm) : prod[2*WIDTH-1:WIDTH];
    new_lo = is_div ? (dz ? '1 : q) : prod[WIDTH-1:0];
  end
  // FSM, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= wr;
      if (state != IDLE && bus.flush) begin
        state <= IDLE;
      end else if (is_md) begin
        state  <= CALC;
        cnt    <= MD_CNT_W'(WIDTH - 1);
        acc    <= {{WIDTH{1'b0}}, op_div ? abs_a : abs_b};
        opnd   <= op_div ? abs_b : abs_a;
        a_raw  <= bus.a;
        is_div <= op_div;
        neg_q  <= sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r  <= sgn_op & bus.a[WIDTH-1];
        dz     <= op_div & (bus.b == '0);
      end else if (state == CALC) begin
        acc   <= acc_next;
        cnt   <= (cnt == 0) ? cnt : cnt - 1'b1;
        state <= (cnt == 0) ? (SGN ? FIX : IDLE) : CALC;
      end else if (state == FIX) begin
        state <= IDLE;
      end
      if (wr) begin
        hi <= new_hi;
        lo <= new_lo;
      end
      if (is_mth) hi <= bus.a;
      if (is_mtl) lo <= bus.a;
    end
  end
  assign bus.busy  = state != IDLE;
  assign bus.stall = (state != IDLE) & (bus.start | bus.mf_read);
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl in either signed or unsigned build
module tb_muldiv_ctrl;
`ifdef MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
  localparam int LAT = 33;
`else
  localparam bit SGN = 1'b0;
  localparam int LAT = 32;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(LAT));
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    tick();
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n, bad;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.a = '0;
    bus.b = '0;
    bus.mf_read = 1'b0;
    bus.flush = 1'b0;
    tick();
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    tick();

    run_op("multu max*2", 3'b001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run_op("mult -3*5", 3'b000, 32'hFFFFFFFD, 32'd5, SGN ? 32'hFFFFFFFF : 32'h00000004, 32'hFFFFFFF1);
    run_op("div -7/2", 3'b010, 32'hFFFFFFF9, 32'd2, SGN ? 32'hFFFFFFFF : 32'h00000001,
           SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC);
    run_op("divu 10/0", 3'b011, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF);
    run_op("div -9/0", 3'b010, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
    run_op("div ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, SGN ? 32'h0 : 32'h80000000,
           SGN ? 32'h80000000 : 32'h0);

    bus.mf_read = 1'b1;
    issue(3'b011, 32'd100, 32'd7);
    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.a = 32'h0000ABCD;
    n = 0;
    bad = 0;
    while (bus.busy && n < 100) begin
      if (!bus.stall) bad++;
      tick();
      n++;
    end
    chk("stall held", 64'(bad), 64'd0);
    chk("stall latency", 64'(n), 64'(LAT));
    chk("stall release", 64'(bus.stall), 64'd0);
    chk("stall done", 64'(bus.done), 64'd1);
    chk("divu 100/7 lo", 64'(bus.lo), 64'd14);
    chk("divu 100/7 hi", 64'(bus.hi), 64'd2);
    tick();
    bus.start = 1'b0;
    bus.mf_read = 1'b0;
    chk("held mthi hi", 64'(bus.hi), 64'h0000ABCD);
    chk("held mthi busy", 64'(bus.busy), 64'd0);
    chk("held mthi lo", 64'(bus.lo), 64'd14);

    issue(3'b001, 32'd6, 32'd7);
    repeat (9) tick();
    chk("pre-flush busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'd0);
    chk("flush hi", 64'(bus.hi), 64'h0000ABCD);
    chk("flush lo", 64'(bus.lo), 64'd14);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) bad++;
      tick();
    end
    chk("flush no done", 64'(bad), 64'd0);
    issue(3'b101, 32'h00001234, 32'd0);
    chk("mtlo lo", 64'(bus.lo), 64'h00001234);
    chk("mtlo busy", 64'(bus.busy), 64'd0);
    chk("mtlo done", 64'(bus.done), 64'd0);

    bus.flush = 1'b1;
    issue(3'b100, 32'h00005555, 32'd0);
    bus.flush = 1'b0;
    chk("idle flush blocks", 64'(bus.hi), 64'h0000ABCD);
    issue(3'b110, 32'h00007777, 32'd3);
    chk("op110 busy", 64'(bus.busy), 64'd0);
    chk("op110 hi", 64'(bus.hi), 64'h0000ABCD);
    chk("op110 lo", 64'(bus.lo), 64'h00001234);

    issue(3'b001, 32'd7, 32'd9);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async rst busy", 64'(bus.busy), 64'd0);
    chk("async rst hi", 64'(bus.hi), 64'd0);
    chk("async rst lo", 64'(bus.lo), 64'd0);
    #2;
    reset = 1'b0;
    tick();
    run_op("multu 3*4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
